mano_control_unit: RTL and testbench

Hardwired control sequencer for the Mano basic computer. It owns the sequence counter, the I, S (run), R and IEN flip-flops, and decodes IR and timing into every register strobe, bus select, memory strobe, and the one-hot operation select that drives the accumulator ALU. The block sits directly upstream of the ALU and beside the register/bus datapath, whose status flags it consumes.

---
 rtl/mano_pkg.sv | 54 +++++
 rtl/mano_seq_counter.sv | 36 +++
 rtl/mano_control_unit.sv | 215 +++++++++++++++++++++
 tb/tb_mano_control_unit.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mano_pkg.sv
// Shared encodings for the Mano basic-computer control unit: bus codes, ALU op bits,
// opcodes, register-reference / I/O bit positions and E-source selects.
package mano_pkg;

  localparam logic [2:0] BUS_NONE = 3'd0;
  localparam logic [2:0] BUS_AR   = 3'd1;
  localparam logic [2:0] BUS_PC   = 3'd2;
  localparam logic [2:0] BUS_DR   = 3'd3;
  localparam logic [2:0] BUS_AC   = 3'd4;
  localparam logic [2:0] BUS_IR   = 3'd5;
  localparam logic [2:0] BUS_TR   = 3'd6;
  localparam logic [2:0] BUS_MEM  = 3'd7;

  localparam int ALU_AND = 5;
  localparam int ALU_ADD = 4;
  localparam int ALU_LDA = 3;
  localparam int ALU_CMA = 2;
  localparam int ALU_CIR = 1;
  localparam int ALU_CIL = 0;

  typedef enum logic [2:0] {
    OP_AND = 3'd0, OP_ADD = 3'd1, OP_LDA = 3'd2, OP_STA = 3'd3,
    OP_BUN = 3'd4, OP_BSA = 3'd5, OP_ISZ = 3'd6, OP_RIO = 3'd7
  } opcode_e;

  typedef enum logic [2:0] {
    T0 = 3'd0, T1 = 3'd1, T2 = 3'd2, T3 = 3'd3, T4 = 3'd4, T5 = 3'd5, T6 = 3'd6
  } tstate_e;

  localparam int RR_CLA = 11;
  localparam int RR_CLE = 10;
  localparam int RR_CMA = 9;
  localparam int RR_CME = 8;
  localparam int RR_CIR = 7;
  localparam int RR_CIL = 6;
  localparam int RR_INC = 5;
  localparam int RR_SPA = 4;
  localparam int RR_SNA = 3;
  localparam int RR_SZA = 2;
  localparam int RR_SZE = 1;
  localparam int RR_HLT = 0;

  localparam int IO_INP = 11;
  localparam int IO_OUT = 10;
  localparam int IO_SKI = 9;
  localparam int IO_SKO = 8;
  localparam int IO_ION = 7;
  localparam int IO_IOF = 6;

  localparam logic [1:0] ESRC_ALU  = 2'd0;
  localparam logic [1:0] ESRC_AC0  = 2'd1;
  localparam logic [1:0] ESRC_AC15 = 2'd2;

endpackage

// File: rtl/mano_seq_counter.sv
// Sequence counter SC with clear/hold and one-hot timing decode.
// state | meaning: T0..T2 fetch/decode (or RT0..RT2), T3 decode/reg-ref/IO, T4..T6 execute
module mano_seq_counter
  import mano_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_clr,
  input  logic       i_hold,
  output tstate_e    o_sc,
  output logic [6:0] o_t
);

  tstate_e r_sc;
  tstate_e w_sc_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sc <= T0;
    else     r_sc <= w_sc_nxt;
  end

  // T6 saturates: only an explicit clear returns SC to T0
  always_comb begin
    w_sc_nxt = r_sc;
    if (i_clr)                      w_sc_nxt = T0;
    else if (!i_hold && r_sc != T6) w_sc_nxt = tstate_e'(r_sc + 3'd1);
  end

  always_comb begin
    o_t       = '0;
    o_t[r_sc] = 1'b1;
  end

  assign o_sc = r_sc;

endmodule

// File: rtl/mano_control_unit.sv
// Hardwired Mano basic-computer control: SC, S, I flip-flops and all datapath strobes.
// Optional interrupt/I-O support (R, IEN, fgi/fgo ports) under `MANO_INTERRUPT_EN.
module mano_control_unit
  import mano_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] ir,
  input  logic        ac15,
  input  logic        ac_zero,
  input  logic        e_flag,
  input  logic        dr_zero,
`ifdef MANO_INTERRUPT_EN
  input  logic        fgi,
  input  logic        fgo,
  output logic        fgi_clr,
  output logic        fgo_clr,
  output logic        outr_ld,
  output logic        ac_ld_inpr,
`endif
  output logic [2:0]  t_state,
  output logic        running,
  output logic [2:0]  bus_sel,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        ar_ld,
  output logic        ar_inr,
  output logic        ar_clr,
  output logic        pc_ld,
  output logic        pc_inr,
  output logic        pc_clr,
  output logic        dr_ld,
  output logic        dr_inr,
  output logic        ir_ld,
  output logic        tr_ld,
  output logic        ac_ld,
  output logic        ac_clr,
  output logic        ac_inr,
  output logic [5:0]  alu_op,
  output logic        e_clr,
  output logic        e_cmp,
  output logic        e_ld,
  output logic [1:0]  e_src
);

  logic       r_s;
  logic       r_i;
  logic       w_r;
  logic       w_sc_clr;
  logic       w_s_clr;
  logic       w_d7;
  logic [6:0] w_t;
  tstate_e    w_sc;
  opcode_e    w_d;

  assign w_d  = opcode_e'(ir[14:12]);
  assign w_d7 = (w_d == OP_RIO);

`ifdef MANO_INTERRUPT_EN
  logic r_r;
  logic r_ien;
  logic w_r_clr;
  logic w_ien_set;
  logic w_ien_clr;

  assign w_r = r_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_r   <= 1'b0;
      r_ien <= 1'b0;
    end else begin
      if (w_r_clr) r_r <= 1'b0;
      else if (!(w_t[0] | w_t[1] | w_t[2]) && r_ien && (fgi | fgo)) r_r <= 1'b1;
      if (w_ien_clr)      r_ien <= 1'b0;
      else if (w_ien_set) r_ien <= 1'b1;
    end
  end
`else
  assign w_r = 1'b0;
`endif

  mano_seq_counter u_sc (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_sc_clr),
    .i_hold (~r_s),
    .o_sc   (w_sc),
    .o_t    (w_t)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s <= 1'b1;
      r_i <= 1'b0;
    end else begin
      if (w_s_clr)           r_s <= 1'b0;
      else if (!r_s && start) r_s <= 1'b1;
      if (r_s && !w_r && w_t[2]) r_i <= ir[15];
    end
  end

  assign t_state = w_sc;
  assign running = r_s;

  always_comb begin
    bus_sel  = BUS_NONE;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    ar_ld    = 1'b0;
    ar_inr   = 1'b0;
    ar_clr   = 1'b0;
    pc_ld    = 1'b0;
    pc_inr   = 1'b0;
    pc_clr   = 1'b0;
    dr_ld    = 1'b0;
    dr_inr   = 1'b0;
    ir_ld    = 1'b0;
    tr_ld    = 1'b0;
    ac_ld    = 1'b0;
    ac_clr   = 1'b0;
    ac_inr   = 1'b0;
    alu_op   = '0;
    e_clr    = 1'b0;
    e_cmp    = 1'b0;
    e_ld     = 1'b0;
    e_src    = ESRC_ALU;
    w_sc_clr = 1'b0;
    w_s_clr  = 1'b0;
`ifdef MANO_INTERRUPT_EN
    fgi_clr    = 1'b0;
    fgo_clr    = 1'b0;
    outr_ld    = 1'b0;
    ac_ld_inpr = 1'b0;
    w_r_clr    = 1'b0;
    w_ien_set  = 1'b0;
    w_ien_clr  = 1'b0;
`endif
    if (!rst && r_s) begin
`ifdef MANO_INTERRUPT_EN
      if (r_r) begin
        if (w_t[0]) begin ar_clr = 1'b1; bus_sel = BUS_PC; tr_ld = 1'b1; end
        if (w_t[1]) begin bus_sel = BUS_TR; mem_wr = 1'b1; pc_clr = 1'b1; end
        if (w_t[2]) begin
          pc_inr = 1'b1; w_ien_clr = 1'b1; w_r_clr = 1'b1; w_sc_clr = 1'b1;
        end
      end else
`endif
      begin
        if (w_t[0]) begin bus_sel = BUS_PC; ar_ld = 1'b1; end
        if (w_t[1]) begin bus_sel = BUS_MEM; mem_rd = 1'b1; ir_ld = 1'b1; pc_inr = 1'b1; end
        if (w_t[2]) begin bus_sel = BUS_IR; ar_ld = 1'b1; end
      end

      if (w_t[3]) begin
        if (w_d7 && !r_i) begin
          w_sc_clr = 1'b1;
          if (ir[RR_CLA]) ac_clr = 1'b1;
          if (ir[RR_CLE]) e_clr = 1'b1;
          if (ir[RR_CMA]) begin ac_ld = 1'b1; alu_op[ALU_CMA] = 1'b1; end
          if (ir[RR_CME]) e_cmp = 1'b1;
          if (ir[RR_CIR]) begin ac_ld = 1'b1; alu_op[ALU_CIR] = 1'b1; e_ld = 1'b1; e_src = ESRC_AC0; end
          if (ir[RR_CIL]) begin ac_ld = 1'b1; alu_op[ALU_CIL] = 1'b1; e_ld = 1'b1; e_src = ESRC_AC15; end
          if (ir[RR_INC]) ac_inr = 1'b1;
          // all selected skip conditions merge into one PC increment
          pc_inr = (ir[RR_SPA] & ~ac15) | (ir[RR_SNA] & ac15) |
                   (ir[RR_SZA] & ac_zero) | (ir[RR_SZE] & ~e_flag);
          if (ir[RR_HLT]) w_s_clr = 1'b1;
        end else if (w_d7) begin
          w_sc_clr = 1'b1;
`ifdef MANO_INTERRUPT_EN
          if (ir[IO_INP]) begin ac_ld_inpr = 1'b1; fgi_clr = 1'b1; end
          if (ir[IO_OUT]) begin bus_sel = BUS_AC; outr_ld = 1'b1; fgo_clr = 1'b1; end
          pc_inr = (ir[IO_SKI] & fgi) | (ir[IO_SKO] & fgo);
          if (ir[IO_ION]) w_ien_set = 1'b1;
          if (ir[IO_IOF]) w_ien_clr = 1'b1;
`endif
        end else if (r_i) begin
          bus_sel = BUS_MEM; mem_rd = 1'b1; ar_ld = 1'b1;
        end
      end

      if (!w_d7) begin
        case (w_d)
          OP_AND, OP_ADD, OP_LDA: begin
            if (w_t[4]) begin bus_sel = BUS_MEM; mem_rd = 1'b1; dr_ld = 1'b1; end
            if (w_t[5]) begin
              ac_ld    = 1'b1;
              w_sc_clr = 1'b1;
              if (w_d == OP_AND) alu_op[ALU_AND] = 1'b1;
              if (w_d == OP_LDA) alu_op[ALU_LDA] = 1'b1;
              if (w_d == OP_ADD) begin alu_op[ALU_ADD] = 1'b1; e_ld = 1'b1; end
            end
          end
          OP_STA: if (w_t[4]) begin bus_sel = BUS_AC; mem_wr = 1'b1; w_sc_clr = 1'b1; end
          OP_BUN: if (w_t[4]) begin bus_sel = BUS_AR; pc_ld = 1'b1; w_sc_clr = 1'b1; end
          OP_BSA: begin
            if (w_t[4]) begin bus_sel = BUS_PC; mem_wr = 1'b1; ar_inr = 1'b1; end
            if (w_t[5]) begin bus_sel = BUS_AR; pc_ld = 1'b1; w_sc_clr = 1'b1; end
          end
          OP_ISZ: begin
            if (w_t[4]) begin bus_sel = BUS_MEM; mem_rd = 1'b1; dr_ld = 1'b1; end
            if (w_t[5]) dr_inr = 1'b1;
            if (w_t[6]) begin
              bus_sel = BUS_DR; mem_wr = 1'b1; pc_inr = dr_zero; w_sc_clr = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mano_control_unit.sv
// Self-checking bench for mano_control_unit: directed scenarios plus randomized
// instruction streams compared against a per-instruction micro-operation model.
module tb_mano_control_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] ir = '0;
  logic        ac15 = 1'b0, ac_zero = 1'b0, e_flag = 1'b0, dr_zero = 1'b0;
  logic [2:0]  t_state, bus_sel;
  logic        running, mem_rd, mem_wr;
  logic        ar_ld, ar_inr, ar_clr, pc_ld, pc_inr, pc_clr, dr_ld, dr_inr, ir_ld, tr_ld;
  logic        ac_ld, ac_clr, ac_inr, e_clr, e_cmp, e_ld;
  logic [5:0]  alu_op;
  logic [1:0]  e_src;
`ifdef MANO_INTERRUPT_EN
  logic        fgi = 1'b0, fgo = 1'b0;
  logic        fgi_clr, fgo_clr, outr_ld, ac_ld_inpr;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  mano_control_unit dut (
    .clk(clk), .rst(rst), .start(start), .ir(ir),
    .ac15(ac15), .ac_zero(ac_zero), .e_flag(e_flag), .dr_zero(dr_zero),
`ifdef MANO_INTERRUPT_EN
    .fgi(fgi), .fgo(fgo), .fgi_clr(fgi_clr), .fgo_clr(fgo_clr),
    .outr_ld(outr_ld), .ac_ld_inpr(ac_ld_inpr),
`endif
    .t_state(t_state), .running(running), .bus_sel(bus_sel),
    .mem_rd(mem_rd), .mem_wr(mem_wr),
    .ar_ld(ar_ld), .ar_inr(ar_inr), .ar_clr(ar_clr),
    .pc_ld(pc_ld), .pc_inr(pc_inr), .pc_clr(pc_clr),
    .dr_ld(dr_ld), .dr_inr(dr_inr), .ir_ld(ir_ld), .tr_ld(tr_ld),
    .ac_ld(ac_ld), .ac_clr(ac_clr), .ac_inr(ac_inr), .alu_op(alu_op),
    .e_clr(e_clr), .e_cmp(e_cmp), .e_ld(e_ld), .e_src(e_src)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] t;
    logic       run;
    logic [2:0] bus;
    logic rd, wr, ar_ld, ar_inr, ar_clr, pc_ld, pc_inr, pc_clr;
    logic dr_ld, dr_inr, ir_ld, tr_ld, ac_ld, ac_clr, ac_inr;
    logic [5:0] alu;
    logic e_clr, e_cmp, e_ld;
    logic [1:0] e_src;
  } obs_t;

  function automatic obs_t observe();
    obs_t o;
    o = '{t: t_state, run: running, bus: bus_sel, rd: mem_rd, wr: mem_wr,
          ar_ld: ar_ld, ar_inr: ar_inr, ar_clr: ar_clr, pc_ld: pc_ld, pc_inr: pc_inr,
          pc_clr: pc_clr, dr_ld: dr_ld, dr_inr: dr_inr, ir_ld: ir_ld, tr_ld: tr_ld,
          ac_ld: ac_ld, ac_clr: ac_clr, ac_inr: ac_inr, alu: alu_op,
          e_clr: e_clr, e_cmp: e_cmp, e_ld: e_ld, e_src: e_src};
    return o;
  endfunction

  function automatic obs_t fetch_t0();
    obs_t o;
    o = '0; o.run = 1'b1; o.bus = 3'd2; o.ar_ld = 1'b1;
    return o;
  endfunction

  // cycles an instruction occupies from T0 to its final step
  function automatic int instr_len(input logic [15:0] instr);
    case (instr[14:12])
      3'd7:       return 4;
      3'd3, 3'd4: return 5;
      3'd6:       return 7;
      default:    return 6;
    endcase
  endfunction

  // expected outputs during one step of one instruction, from its micro-operation list
  function automatic obs_t model(input logic [15:0] instr, input int step,
                                 input logic a15, input logic az, input logic ef, input logic dz);
    obs_t o;
    logic [2:0] op;
    logic [5:0] top_bit;
    top_bit = 6'b100000;
    op = instr[14:12];
    o = '0;
    o.t = step[2:0];
    o.run = 1'b1;
    if (step == 0) begin o.bus = 3'd2; o.ar_ld = 1'b1; end
    else if (step == 1) begin o.bus = 3'd7; o.rd = 1'b1; o.ir_ld = 1'b1; o.pc_inr = 1'b1; end
    else if (step == 2) begin o.bus = 3'd5; o.ar_ld = 1'b1; end
    else if (op == 3'd7) begin
      if (!instr[15]) begin
        for (int b = 0; b < 12; b++) begin
          if (instr[b]) begin
            case (b)
              11: o.ac_clr = 1'b1;
              10: o.e_clr = 1'b1;
              9:  begin o.ac_ld = 1'b1; o.alu[2] = 1'b1; end
              8:  o.e_cmp = 1'b1;
              7:  begin o.ac_ld = 1'b1; o.alu[1] = 1'b1; o.e_ld = 1'b1; o.e_src = 2'd1; end
              6:  begin o.ac_ld = 1'b1; o.alu[0] = 1'b1; o.e_ld = 1'b1; o.e_src = 2'd2; end
              5:  o.ac_inr = 1'b1;
              4:  if (!a15) o.pc_inr = 1'b1;
              3:  if (a15) o.pc_inr = 1'b1;
              2:  if (az) o.pc_inr = 1'b1;
              1:  if (!ef) o.pc_inr = 1'b1;
              default: ;
            endcase
          end
        end
      end
`ifdef MANO_INTERRUPT_EN
      else if (instr[10]) o.bus = 3'd4;
`endif
    end else if (step == 3) begin
      if (instr[15]) begin o.bus = 3'd7; o.rd = 1'b1; o.ar_ld = 1'b1; end
    end else begin
      case (op)
        3'd0, 3'd1, 3'd2: begin
          if (step == 4) begin o.bus = 3'd7; o.rd = 1'b1; o.dr_ld = 1'b1; end
          if (step == 5) begin o.ac_ld = 1'b1; o.alu = top_bit >> op; o.e_ld = (op == 3'd1); end
        end
        3'd3: begin o.bus = 3'd4; o.wr = 1'b1; end
        3'd4: begin o.bus = 3'd1; o.pc_ld = 1'b1; end
        3'd5: begin
          if (step == 4) begin o.bus = 3'd2; o.wr = 1'b1; o.ar_inr = 1'b1; end
          if (step == 5) begin o.bus = 3'd1; o.pc_ld = 1'b1; end
        end
        default: begin
          if (step == 4) begin o.bus = 3'd7; o.rd = 1'b1; o.dr_ld = 1'b1; end
          if (step == 5) o.dr_inr = 1'b1;
          if (step == 6) begin o.bus = 3'd3; o.wr = 1'b1; o.pc_inr = dz; end
        end
      endcase
    end
    return o;
  endfunction

  // leaves the bench just after a falling edge with reset released; DUT is in T0
  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0; ir = '0;
    ac15 = 1'b0; ac_zero = 1'b0; e_flag = 1'b0; dr_zero = 1'b0;
`ifdef MANO_INTERRUPT_EN
    fgi = 1'b0; fgo = 1'b0;
`endif
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    obs_t exp, got;
    @(negedge clk);
    rst = 1'b1; ir = '0;
    @(negedge clk); #1;
    exp = '0; exp.run = 1'b1;
    got = observe(); n_cmp++;
    if (got !== exp) begin n_bad++; $display("FAIL reset_hold: got %h expected %h", got, exp); end
    @(negedge clk);
    rst = 1'b0; #1;
    exp = fetch_t0();
    got = observe(); n_cmp++;
    if (got !== exp) begin n_bad++; $display("FAIL reset_t0: got %h expected %h", got, exp); end
    @(negedge clk); #1;
    exp = '0; exp.run = 1'b1; exp.t = 3'd1; exp.bus = 3'd7;
    exp.rd = 1'b1; exp.ir_ld = 1'b1; exp.pc_inr = 1'b1;
    got = observe(); n_cmp++;
    if (got !== exp) begin n_bad++; $display("FAIL reset_t1: got %h expected %h", got, exp); end
  endtask

  task automatic test_add();
    obs_t exp, got;
    apply_reset();
    ir = 16'h1123; #1;
    repeat (5) @(negedge clk);
    #1;
    exp = '0; exp.run = 1'b1; exp.t = 3'd5; exp.ac_ld = 1'b1; exp.alu = 6'b010000; exp.e_ld = 1'b1;
    got = observe(); n_cmp++;
    if (got !== exp) begin n_bad++; $display("FAIL add_t5: got %h expected %h", got, exp); end
    @(negedge clk); #1;
    exp = fetch_t0();
    got = observe(); n_cmp++;
    if (got !== exp) begin n_bad++; $display("FAIL add_wrap: got %h expected %h", got, exp); end
  endtask

  task automatic test_cil();
    obs_t exp, got;
    apply_reset();
    ir = 16'h7040; #1;
    repeat (3) @(negedge clk);
    #1;
    exp = '0; exp.run = 1'b1; exp.t = 3'd3; exp.ac_ld = 1'b1; exp.alu = 6'b000001;
    exp.e_ld = 1'b1; exp.e_src = 2'd2;
    got = observe(); n_cmp++;
    if (got !== exp) begin n_bad++; $display("FAIL cil_t3: got %h expected %h", got, exp); end
    @(negedge clk); #1;
    exp = fetch_t0();
    got = observe(); n_cmp++;
    if (got !== exp) begin n_bad++; $display("FAIL cil_wrap: got %h expected %h", got, exp); end
  endtask

  task automatic test_isz();
    obs_t exp, got;
    apply_reset();
    ir = 16'h6200; dr_zero = 1'b1; #1;
    repeat (6) @(negedge clk);
    #1;
    exp = '0; exp.run = 1'b1; exp.t = 3'd6; exp.bus = 3'd3; exp.wr = 1'b1; exp.pc_inr = 1'b1;
    got = observe(); n_cmp++;
    if (got !== exp) begin n_bad++; $display("FAIL isz_skip: got %h expected %h", got, exp); end
    dr_zero = 1'b0;
    repeat (7) @(negedge clk);
    #1;
    exp.pc_inr = 1'b0;
    got = observe(); n_cmp++;
    if (got !== exp) begin n_bad++; $display("FAIL isz_noskip: got %h expected %h", got, exp); end
  endtask

  task automatic test_hlt();
    obs_t exp, got;
    apply_reset();
    ir = 16'h7001; #1;
    repeat (3) @(negedge clk);
    #1;
    exp = '0; exp.run = 1'b1; exp.t = 3'd3;
    got = observe(); n_cmp++;
    if (got !== exp) begin n_bad++; $display("FAIL hlt_t3: got %h expected %h", got, exp); end
    exp = '0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); #1;
      got = observe(); n_cmp++;
      if (got !== exp) begin n_bad++; $display("FAIL hlt_frozen c=%0d: got %h expected %h", c, got, exp); end
    end
    @(negedge clk);
    start = 1'b1; #1;
    got = observe(); n_cmp++;
    if (got !== exp) begin n_bad++; $display("FAIL hlt_start_cycle: got %h expected %h", got, exp); end
    @(negedge clk);
    start = 1'b0; ir = 16'h0000; #1;
    exp = fetch_t0();
    got = observe(); n_cmp++;
    if (got !== exp) begin n_bad++; $display("FAIL hlt_resume: got %h expected %h", got, exp); end
  endtask

  task automatic test_reset_mid();
    obs_t exp, got;
    apply_reset();
    ir = 16'h6200; #1;
    repeat (4) @(negedge clk);
    #1;
    exp = '0; exp.run = 1'b1; exp.t = 3'd4; exp.bus = 3'd7; exp.rd = 1'b1; exp.dr_ld = 1'b1;
    got = observe(); n_cmp++;
    if (got !== exp) begin n_bad++; $display("FAIL midrst_t4: got %h expected %h", got, exp); end
    #1 rst = 1'b1;
    #1;
    exp = '0; exp.run = 1'b1;
    got = observe(); n_cmp++;
    if (got !== exp) begin n_bad++; $display("FAIL midrst_abort: got %h expected %h", got, exp); end
    @(negedge clk);
    rst = 1'b0; #1;
    exp = fetch_t0();
    got = observe(); n_cmp++;
    if (got !== exp) begin n_bad++; $display("FAIL midrst_restart: got %h expected %h", got, exp); end
  endtask

  task automatic test_back_to_back();
    obs_t exp, got;
    logic [15:0] instr;
    bit first;
    bit halt;
    apply_reset();
    first = 1'b1;
    for (int k = 0; k < 60; k++) begin
      instr = 16'($urandom);
      if (instr[14:12] == 3'd7 && !instr[15]) begin
        if (instr[7]) instr[6] = 1'b0;
        if ($urandom_range(0, 5) != 0) instr[0] = 1'b0;
      end
      halt = (instr[14:12] == 3'd7) && !instr[15] && instr[0];
      for (int s = 0; s < instr_len(instr); s++) begin
        if (!first) @(negedge clk);
        first = 1'b0;
        start = 1'b0;
        ir = instr;
        ac15 = 1'($urandom_range(0, 1));
        ac_zero = 1'($urandom_range(0, 1));
        e_flag = 1'($urandom_range(0, 1));
        dr_zero = 1'($urandom_range(0, 1));
        #1;
        exp = model(instr, s, ac15, ac_zero, e_flag, dr_zero);
        got = observe(); n_cmp++;
        if (got !== exp) begin
          n_bad++;
          $display("FAIL rand k=%0d ir=%h step=%0d: got %h expected %h", k, instr, s, got, exp);
        end
      end
      if (halt) begin
        exp = '0;
        for (int c = 0; c < 4; c++) begin
          @(negedge clk);
          if (c == 3) start = 1'b1;
          #1;
          got = observe(); n_cmp++;
          if (got !== exp) begin n_bad++; $display("FAIL rand_halted k=%0d c=%0d: got %h expected %h", k, c, got, exp); end
        end
      end
    end
  endtask

`ifdef MANO_INTERRUPT_EN
  task automatic test_interrupt();
    obs_t exp, got;
    apply_reset();
    ir = 16'hF080; #1;
    repeat (3) @(negedge clk);
    #1;
    exp = '0; exp.run = 1'b1; exp.t = 3'd3;
    got = observe(); n_cmp++;
    if (got !== exp) begin n_bad++; $display("FAIL int_ion: got %h expected %h", got, exp); end
    @(negedge clk);
    ir = 16'h7020; fgi = 1'b1; #1;
    exp = fetch_t0();
    got = observe(); n_cmp++;
    if (got !== exp) begin n_bad++; $display("FAIL int_fetch_before: got %h expected %h", got, exp); end
    repeat (3) @(negedge clk);
    #1;
    exp = '0; exp.run = 1'b1; exp.t = 3'd3; exp.ac_inr = 1'b1;
    got = observe(); n_cmp++;
    if (got !== exp) begin n_bad++; $display("FAIL int_inc: got %h expected %h", got, exp); end
    @(negedge clk); #1;
    exp = '0; exp.run = 1'b1; exp.bus = 3'd2; exp.ar_clr = 1'b1; exp.tr_ld = 1'b1;
    got = observe(); n_cmp++;
    if (got !== exp) begin n_bad++; $display("FAIL int_rt0: got %h expected %h", got, exp); end
    @(negedge clk); #1;
    exp = '0; exp.run = 1'b1; exp.t = 3'd1; exp.bus = 3'd6; exp.wr = 1'b1; exp.pc_clr = 1'b1;
    got = observe(); n_cmp++;
    if (got !== exp) begin n_bad++; $display("FAIL int_rt1: got %h expected %h", got, exp); end
    @(negedge clk); #1;
    exp = '0; exp.run = 1'b1; exp.t = 3'd2; exp.pc_inr = 1'b1;
    got = observe(); n_cmp++;
    if (got !== exp) begin n_bad++; $display("FAIL int_rt2: got %h expected %h", got, exp); end
    @(negedge clk); #1;
    exp = fetch_t0();
    got = observe(); n_cmp++;
    if (got !== exp) begin n_bad++; $display("FAIL int_after_rt: got %h expected %h", got, exp); end
    repeat (4) @(negedge clk);
    #1;
    got = observe(); n_cmp++;
    if (got !== exp) begin n_bad++; $display("FAIL int_ien_off: got %h expected %h", got, exp); end
    fgi = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_add();
    test_cil();
    test_isz();
    test_hlt();
    test_reset_mid();
    test_back_to_back();
`ifdef MANO_INTERRUPT_EN
    test_interrupt();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
